// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared types and constants for the IR scan scheduler and its error
// calculator: FSM state encoding, reading width, sensor weights and the
// saturation limits of the 16-bit signed line-position error.
// No ports (package).
// ---------------------------------------------------------------------------
package ir_pkg;

  localparam int RD_W  = 12;
  localparam int RAW_W = 18;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  // Inner sensors weigh least, outer sensors most, so the error grows with
  // how far the line has drifted from centre.
  localparam logic signed [RAW_W-1:0] W0 = 18'sd1;
  localparam logic signed [RAW_W-1:0] W1 = 18'sd2;
  localparam logic signed [RAW_W-1:0] W2 = 18'sd4;
  localparam logic signed [RAW_W-1:0] W3 = 18'sd8;

  localparam logic signed [15:0] ERR_MAX = 16'sh7FFF;
  localparam logic signed [15:0] ERR_MIN = 16'sh8000;

  // Clamp the wide weighted sum into the 16-bit signed error range.
  function automatic logic signed [15:0] sat16(input logic signed [RAW_W-1:0] raw);
    if (raw > 18'sd32767) begin
      return ERR_MAX;
    end else if (raw < -18'sd32768) begin
      return ERR_MIN;
    end else begin
      return raw[15:0];
    end
  endfunction

endpackage

// File: rtl/ir_err_calc.sv
// ---------------------------------------------------------------------------
// ir_err_calc
// Purely combinational: weighted right-minus-left difference of the eight
// IR readings, saturated to a 16-bit signed error. The caller registers it.
// Ports:
//   i_r0..i_r3  right-side readings, unsigned, R0 innermost
//   i_l0..i_l3  left-side readings, unsigned, L0 innermost
//   o_error     saturated signed line-position error
// ---------------------------------------------------------------------------
module ir_err_calc
  import ir_pkg::*;
(
  input  logic        [RD_W-1:0] i_r0,
  input  logic        [RD_W-1:0] i_r1,
  input  logic        [RD_W-1:0] i_r2,
  input  logic        [RD_W-1:0] i_r3,
  input  logic        [RD_W-1:0] i_l0,
  input  logic        [RD_W-1:0] i_l1,
  input  logic        [RD_W-1:0] i_l2,
  input  logic        [RD_W-1:0] i_l3,
  output logic signed [15:0]     o_error
);

  localparam int PAD = RAW_W - RD_W;

  logic signed [RAW_W-1:0] w_d0;
  logic signed [RAW_W-1:0] w_d1;
  logic signed [RAW_W-1:0] w_d2;
  logic signed [RAW_W-1:0] w_d3;
  logic signed [RAW_W-1:0] w_raw;

  // Zero-extend before subtracting so each difference is a proper signed value.
  assign w_d0 = $signed({{PAD{1'b0}}, i_r0}) - $signed({{PAD{1'b0}}, i_l0});
  assign w_d1 = $signed({{PAD{1'b0}}, i_r1}) - $signed({{PAD{1'b0}}, i_l1});
  assign w_d2 = $signed({{PAD{1'b0}}, i_r2}) - $signed({{PAD{1'b0}}, i_l2});
  assign w_d3 = $signed({{PAD{1'b0}}, i_r3}) - $signed({{PAD{1'b0}}, i_l3});

  // Worst case is 15 * 4095, well inside 18-bit signed, so no intermediate overflow.
  assign w_raw = w_d0 * W0 + w_d1 * W1 + w_d2 * W2 + w_d3 * W3;

  assign o_error = sat16(w_raw);

endmodule

// File: rtl/ir_scan_sched.sv
// ---------------------------------------------------------------------------
// ir_scan_sched
// Issues periodic scan requests to the IR front end, watches each scan with a
// timeout, converts accepted readings into a registered line-position error
// and tracks consecutive line-absent scans.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_run                 level, scheduling enabled
//   i_clr_err             pulse, clears o_timeout_err
//   o_scan_go             one-cycle scan start pulse
//   i_ir_vld              result valid from the IR interface (used in WAIT only)
//   i_line_present        qualifies the readings, sampled with i_ir_vld
//   i_ir_r0..3/i_ir_l0..3 12-bit sensor readings
//   o_error, o_err_vld    saturated signed error and its one-cycle strobe
//   o_line_lost           line absent for MISS_LIM consecutive scans
//   o_timeout_err         sticky scan-timeout flag
//   o_busy                high while a scan is requested or outstanding
// ---------------------------------------------------------------------------
module ir_scan_sched
  import ir_pkg::*;
#(
  parameter int PERIOD   = 4096,
  parameter int TIMEOUT  = 30000,
  parameter int MISS_LIM = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_run,
  input  logic                   i_clr_err,
  output logic                   o_scan_go,
  input  logic                   i_ir_vld,
  input  logic                   i_line_present,
  input  logic        [RD_W-1:0] i_ir_r0,
  input  logic        [RD_W-1:0] i_ir_r1,
  input  logic        [RD_W-1:0] i_ir_r2,
  input  logic        [RD_W-1:0] i_ir_r3,
  input  logic        [RD_W-1:0] i_ir_l0,
  input  logic        [RD_W-1:0] i_ir_l1,
  input  logic        [RD_W-1:0] i_ir_l2,
  input  logic        [RD_W-1:0] i_ir_l3,
  output logic signed [15:0]     o_error,
  output logic                   o_err_vld,
  output logic                   o_line_lost,
  output logic                   o_timeout_err,
  output logic                   o_busy
);

  localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  MISS_MAX = 8'(MISS_LIM);

  state_t             r_state;
  logic [15:0]        r_period;
  logic [15:0]        r_tmo;
  logic [7:0]         r_miss;
  logic               r_scan_go;
  logic               r_busy;
  logic signed [15:0] r_error;
  logic               r_err_vld;
  logic               r_line_lost;
  logic               r_timeout_err;
  logic signed [15:0] w_calc;

  ir_err_calc u_err_calc (
    .i_r0    (i_ir_r0),
    .i_r1    (i_ir_r1),
    .i_r2    (i_ir_r2),
    .i_r3    (i_ir_r3),
    .i_l0    (i_ir_l0),
    .i_l1    (i_ir_l1),
    .i_l2    (i_ir_l2),
    .i_l3    (i_ir_l3),
    .o_error (w_calc)
  );

  // Scheduler FSM with all outputs registered. The period counter is loaded
  // with 1 in REQ so that it holds the number of cycles since scan_go; HOLD
  // leaving at PERIOD-1 then spaces scan_go pulses exactly PERIOD apart, and
  // the >= compare covers scans that overran the period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_period      <= '0;
      r_tmo         <= '0;
      r_miss        <= '0;
      r_scan_go     <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= '0;
      r_err_vld     <= 1'b0;
      r_line_lost   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_err_vld   <= 1'b0;
      r_line_lost <= (r_miss == MISS_MAX);
      if (r_period != 16'hFFFF) begin
        r_period <= r_period + 16'd1;
      end
      // A timeout set later in this block overrides the clear.
      if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end

      if (!i_run) begin
        r_state   <= IDLE;
        r_scan_go <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state   <= REQ;
            r_scan_go <= 1'b1;
            r_busy    <= 1'b1;
          end
          REQ: begin
            r_state   <= WAIT;
            r_scan_go <= 1'b0;
            r_period  <= 16'd1;
            r_tmo     <= '0;
          end
          WAIT: begin
            // A valid result in the limit cycle still counts as on time.
            if (i_ir_vld) begin
              r_state <= HOLD;
              r_busy  <= 1'b0;
              if (i_line_present) begin
                r_error     <= w_calc;
                r_err_vld   <= 1'b1;
                r_miss      <= '0;
                r_line_lost <= 1'b0;
              end else if (r_miss != MISS_MAX) begin
                r_miss <= r_miss + 8'd1;
              end
            end else if (r_tmo == TMO_LAST) begin
              r_state       <= HOLD;
              r_busy        <= 1'b0;
              r_timeout_err <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 16'd1;
            end
          end
          HOLD: begin
            if (r_period >= PER_LAST) begin
              r_state   <= REQ;
              r_scan_go <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_scan_go <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_scan_go     = r_scan_go;
  assign o_busy        = r_busy;
  assign o_error       = r_error;
  assign o_err_vld     = r_err_vld;
  assign o_line_lost   = r_line_lost;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ir_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_ir_scan_sched
// Directed bench for ir_scan_sched. Expected errors are hand-computed and
// queued when a result is returned to the DUT; a monitor pops and compares on
// every err_vld. Timing, timeout, miss and reset behaviour are checked inline.
// TIMEOUT is shortened so a timed-out scan still fits inside one period.
// ---------------------------------------------------------------------------
module tb_ir_scan_sched;

  localparam int PERIOD   = 4096;
  localparam int TIMEOUT  = 1000;
  localparam int MISS_LIM = 3;

  typedef struct {
    logic signed [15:0] err;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  logic run = 1'b0;
  logic clrErr = 1'b0;
  logic irVld = 1'b0;
  logic linePresent = 1'b0;
  logic [11:0] rIn [4];
  logic [11:0] lIn [4];

  logic               scanGo;
  logic signed [15:0] error;
  logic               errVld;
  logic               lineLost;
  logic               timeoutErr;
  logic               busy;

  int checkCount = 0;
  int errCount = 0;
  int cyc = 0;
  int busyRun = 0;
  int lastBusyLen = 0;
  exp_t sbQ [$];

  ir_scan_sched #(
    .PERIOD   (PERIOD),
    .TIMEOUT  (TIMEOUT),
    .MISS_LIM (MISS_LIM)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_run          (run),
    .i_clr_err      (clrErr),
    .o_scan_go      (scanGo),
    .i_ir_vld       (irVld),
    .i_line_present (linePresent),
    .i_ir_r0        (rIn[0]),
    .i_ir_r1        (rIn[1]),
    .i_ir_r2        (rIn[2]),
    .i_ir_r3        (rIn[3]),
    .i_ir_l0        (lIn[0]),
    .i_ir_l1        (lIn[1]),
    .i_ir_l2        (lIn[2]),
    .i_ir_l3        (lIn[3]),
    .o_error        (error),
    .o_err_vld      (errVld),
    .o_line_lost    (lineLost),
    .o_timeout_err  (timeoutErr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: during cycle c (after its rising edge) cyc equals c.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Wait (at falling edges) until the given cycle index.
  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Find the next scan_go pulse within a bounded window; also checks its width.
  task automatic waitScanGo(output int goCycle);
    goCycle = -1;
    for (int i = 0; i < PERIOD + TIMEOUT + 100 && goCycle < 0; i++) begin
      @(negedge clk);
      if (scanGo) goCycle = cyc;
    end
    if (goCycle < 0) begin
      checkCount++;
      errCount++;
      $display("[TB] FAIL scanGoWait: got no scan_go expected one within %0d cycles",
               PERIOD + TIMEOUT + 100);
    end else begin
      @(negedge clk);
      checkOutput("scanGoWidth", {31'b0, scanGo}, 32'd0);
    end
  endtask

  // Return one result to the DUT for a single cycle; queue the expected error.
  task automatic applyStimulus(input logic [47:0] rv, input logic [47:0] lv,
                               input logic present, input logic pushExp,
                               input logic signed [15:0] expErr, output int vCycle);
    for (int i = 0; i < 4; i++) begin
      rIn[i] = rv[12*i +: 12];
      lIn[i] = lv[12*i +: 12];
    end
    linePresent = present;
    irVld = 1'b1;
    vCycle = cyc;
    if (pushExp) sbQ.push_back('{expErr, cyc + 1});
    @(negedge clk);
    irVld = 1'b0;
    linePresent = 1'b0;
  endtask

  // Monitor: scoreboard compare on err_vld, pulse width, busy run length.
  initial begin
    logic prevVld;
    exp_t e;
    prevVld = 1'b0;
    forever begin
      @(negedge clk);
      if (rstN && errVld) begin
        if (sbQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpectedErrVld: got err_vld=1 error=%0d expected no err_vld",
                   error);
        end else begin
          e = sbQ.pop_front();
          checkOutput("errValue", {16'b0, error}, {16'b0, e.err});
          checkOutput("errLatency", cyc, e.cyc);
          checkOutput("lineLostWithVld", {31'b0, lineLost}, 32'd0);
        end
        checkOutput("errVldWidth", {31'b0, prevVld}, 32'd0);
      end
      prevVld = errVld;
      if (busy) begin
        busyRun++;
      end else if (busyRun != 0) begin
        lastBusyLen = busyRun;
        busyRun = 0;
      end
    end
  end

  initial begin
    int g;
    int prev;
    int v;
    int runCycle;
    for (int i = 0; i < 4; i++) begin
      rIn[i] = '0;
      lIn[i] = '0;
    end

    // Reset state
    #2 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstScanGo", {31'b0, scanGo}, 32'd0);
    checkOutput("rstError", {16'b0, error}, 32'd0);
    checkOutput("rstErrVld", {31'b0, errVld}, 32'd0);
    checkOutput("rstLineLost", {31'b0, lineLost}, 32'd0);
    checkOutput("rstTimeout", {31'b0, timeoutErr}, 32'd0);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // First scan_go one cycle after run; balanced readings give zero error
    $display("[TB] periodic scans and error values");
    run = 1'b1;
    runCycle = cyc;
    waitScanGo(g);
    checkOutput("firstScanGo", g, runCycle + 1);
    waitUntil(g + 200);
    applyStimulus(48'h7A5_7A5_7A5_7A5, 48'h7A5_7A5_7A5_7A5, 1'b1, 1'b1, 16'sh0000, v);

    // R2=R3=FFF: 12*4095 = 49140 saturates high
    prev = g;
    waitScanGo(g);
    checkOutput("busyLen1", lastBusyLen, 201);
    checkOutput("period1", g - prev, PERIOD);
    waitUntil(g + 200);
    applyStimulus(48'hFFF_FFF_000_000, 48'h0, 1'b1, 1'b1, 16'sh7FFF, v);

    // Mirrored on the left saturates low
    prev = g;
    waitScanGo(g);
    checkOutput("busyLen2", lastBusyLen, 201);
    checkOutput("period2", g - prev, PERIOD);
    waitUntil(g + 200);
    applyStimulus(48'h0, 48'hFFF_FFF_000_000, 1'b1, 1'b1, 16'sh8000, v);

    // R0=0x100 alone
    prev = g;
    waitScanGo(g);
    checkOutput("period3", g - prev, PERIOD);
    waitUntil(g + 200);
    applyStimulus(48'h000_000_000_100, 48'h0, 1'b1, 1'b1, 16'sh0100, v);

    // Timeout: flag rises after TIMEOUT WAIT cycles, error holds
    $display("[TB] timeout handling");
    prev = g;
    waitScanGo(g);
    checkOutput("period4", g - prev, PERIOD);
    waitUntil(g + TIMEOUT);
    checkOutput("tmoEarly", {31'b0, timeoutErr}, 32'd0);
    @(negedge clk);
    checkOutput("tmoSet", {31'b0, timeoutErr}, 32'd1);
    checkOutput("tmoBusy", {31'b0, busy}, 32'd0);
    checkOutput("tmoErrHeld", {16'b0, error}, 32'h0100);
    @(negedge clk);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    checkOutput("clrErr", {31'b0, timeoutErr}, 32'd0);

    // Second timeout with clr_err in the same cycle: timeout wins
    prev = g;
    waitScanGo(g);
    checkOutput("periodAfterTmo", g - prev, PERIOD);
    waitUntil(g + TIMEOUT);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    checkOutput("clrVsTmo", {31'b0, timeoutErr}, 32'd1);

    // Three line-absent scans raise line_lost, error unchanged
    $display("[TB] line loss tracking");
    for (int k = 1; k <= MISS_LIM; k++) begin
      waitScanGo(g);
      waitUntil(g + 200);
      applyStimulus(48'h000_000_000_FFF, 48'h0, 1'b0, 1'b0, 16'sh0000, v);
      waitUntil(v + 1);
      checkOutput("lostNotYet", {31'b0, lineLost}, 32'd0);
    end
    waitUntil(v + 2);
    checkOutput("lineLost", {31'b0, lineLost}, 32'd1);
    checkOutput("missErrHeld", {16'b0, error}, 32'h0100);

    // Line back: 2*(0x010-0x001) = 30; line_lost drops with err_vld
    waitScanGo(g);
    waitUntil(g + 200);
    checkOutput("lostBeforeReturn", {31'b0, lineLost}, 32'd1);
    applyStimulus(48'h000_000_010_000, 48'h000_000_001_000, 1'b1, 1'b1, 16'sh001E, v);
    waitUntil(v + 3);
    checkOutput("lostCleared", {31'b0, lineLost}, 32'd0);

    // run dropped mid-WAIT: late result is ignored
    $display("[TB] run drop and async reset");
    waitScanGo(g);
    waitUntil(g + 50);
    run = 1'b0;
    @(negedge clk);
    checkOutput("runDropBusy", {31'b0, busy}, 32'd0);
    waitUntil(g + 60);
    applyStimulus(48'h000_000_000_123, 48'h0, 1'b1, 1'b0, 16'sh0000, v);
    repeat (20) @(negedge clk);
    checkOutput("runDropErrHeld", {16'b0, error}, 32'h001E);
    checkOutput("runDropIdle", {31'b0, busy | scanGo}, 32'd0);

    // Async reset mid-WAIT clears everything without a clock edge
    run = 1'b1;
    runCycle = cyc;
    waitScanGo(g);
    checkOutput("restartScanGo", g, runCycle + 1);
    waitUntil(g + 30);
    checkOutput("busyInWait", {31'b0, busy}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("asyncError", {16'b0, error}, 32'd0);
    checkOutput("asyncTimeout", {31'b0, timeoutErr}, 32'd0);
    checkOutput("asyncBusy", {31'b0, busy}, 32'd0);
    checkOutput("asyncScanGo", {31'b0, scanGo}, 32'd0);
    checkOutput("asyncLineLost", {31'b0, lineLost}, 32'd0);
    checkOutput("asyncErrVld", {31'b0, errVld}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("sbEmpty", sbQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
